// File: rtl/hazard_stall_unit_if.sv
// Hazard-control bundle between the pipeline datapath (master) and the stall/flush unit (slave).
// Carries the hazard-detection inputs, the pipeline-register controls and the performance counters.
interface hazard_stall_unit_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       rs1_if_id;
  logic [4:0]       rs2_if_id;
  logic             rs1_used;
  logic             rs2_used;
  logic [4:0]       rd_id_ex;
  logic             mem_read_id_ex;
  logic             branch_taken_ex;
  logic             dmem_req;
  logic             dmem_ready;
  logic             stall_clr;
  logic             pc_write;
  logic             if_id_write;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             ex_mem_write;
  logic             mem_wb_bubble;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_events;
  logic             mem_timeout;

  modport master (
    output rs1_if_id, rs2_if_id, rs1_used, rs2_used, rd_id_ex, mem_read_id_ex,
           branch_taken_ex, dmem_req, dmem_ready, stall_clr,
    input  pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_write, mem_wb_bubble,
           stall_cycles, flush_events, mem_timeout
  );

  modport slave (
    input  rs1_if_id, rs2_if_id, rs1_used, rs2_used, rd_id_ex, mem_read_id_ex,
           branch_taken_ex, dmem_req, dmem_ready, stall_clr,
    output pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_write, mem_wb_bubble,
           stall_cycles, flush_events, mem_timeout
  );
endinterface

// File: rtl/hazard_stall_unit.sv
// Stall/flush controller for the 5-stage pipeline: load-use bubbles, data-memory freezes,
// branch squashes, plus saturating stall/flush counters and a sticky memory-timeout flag.
module hazard_stall_unit #(
  parameter int FLUSH_EXTRA = 1,
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input logic              clk,
  input logic              rst_n,
  hazard_stall_unit_if.slave hz
);

  localparam int WCNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WCNT_W-1:0] WCNT_MAX = WCNT_W'(MEM_TIMEOUT);

  typedef enum logic {RUN, FLUSH} state_e;

  state_e            state_q, state_d;
  logic [3:0]        fcnt_q, fcnt_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic [CNT_W-1:0]  stall_q, stall_d;
  logic [CNT_W-1:0]  flush_q, flush_d;
  logic              timeout_q, timeout_d;
  logic              mstall, luse, stall_inc, flush_inc;

  assign mstall = hz.dmem_req & ~hz.dmem_ready;
  assign luse   = hz.mem_read_id_ex & (hz.rd_id_ex != 5'd0) &
                  ((hz.rs1_used & (hz.rd_id_ex == hz.rs1_if_id)) |
                   (hz.rs2_used & (hz.rd_id_ex == hz.rs2_if_id)));

  // Freeze beats redirect beats squash beats load-use; reset forces every enable low.
  always_comb begin
    hz.pc_write      = 1'b1;
    hz.if_id_write   = 1'b1;
    hz.ex_mem_write  = 1'b1;
    hz.if_id_flush   = 1'b0;
    hz.id_ex_flush   = 1'b0;
    hz.mem_wb_bubble = 1'b0;
    state_d          = state_q;
    fcnt_d           = fcnt_q;
    stall_inc        = 1'b0;
    flush_inc        = 1'b0;
    if (!rst_n) begin
      hz.pc_write     = 1'b0;
      hz.if_id_write  = 1'b0;
      hz.ex_mem_write = 1'b0;
    end else if (mstall) begin
      hz.pc_write      = 1'b0;
      hz.if_id_write   = 1'b0;
      hz.ex_mem_write  = 1'b0;
      hz.mem_wb_bubble = 1'b1;
      stall_inc        = 1'b1;
    end else if (state_q == RUN && hz.branch_taken_ex) begin
      hz.if_id_flush = 1'b1;
      hz.id_ex_flush = 1'b1;
      flush_inc      = 1'b1;
      if (FLUSH_EXTRA > 0) begin
        fcnt_d  = 4'(FLUSH_EXTRA);
        state_d = FLUSH;
      end
    end else if (state_q == FLUSH) begin
      hz.if_id_flush = 1'b1;
      fcnt_d         = fcnt_q - 4'd1;
      if (fcnt_q == 4'd1) state_d = RUN;
    end else if (luse) begin
      hz.pc_write    = 1'b0;
      hz.if_id_write = 1'b0;
      hz.id_ex_flush = 1'b1;
      stall_inc      = 1'b1;
    end
  end

  // The wait counter saturates so a long stall keeps re-asserting the sticky flag after a clear.
  always_comb begin
    wcnt_d = '0;
    if (mstall) wcnt_d = (wcnt_q == WCNT_MAX) ? wcnt_q : wcnt_q + WCNT_W'(1);
    timeout_d = timeout_q | (mstall & (wcnt_d == WCNT_MAX));
    stall_d   = (stall_inc && stall_q != '1) ? stall_q + CNT_W'(1) : stall_q;
    flush_d   = (flush_inc && flush_q != '1) ? flush_q + CNT_W'(1) : flush_q;
    if (hz.stall_clr) begin
      timeout_d = 1'b0;
      stall_d   = '0;
      flush_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RUN;
      fcnt_q    <= '0;
      wcnt_q    <= '0;
      stall_q   <= '0;
      flush_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      fcnt_q    <= fcnt_d;
      wcnt_q    <= wcnt_d;
      stall_q   <= stall_d;
      flush_q   <= flush_d;
      timeout_q <= timeout_d;
    end
  end

  assign hz.stall_cycles = stall_q;
  assign hz.flush_events = flush_q;
  assign hz.mem_timeout  = timeout_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit with FLUSH_EXTRA=2, MEM_TIMEOUT=8 and 4-bit counters
// so saturation is reachable in a handful of cycles.
module tb_hazard_stall_unit;

  localparam int CW = 4;

  // {pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_write, mem_wb_bubble}
  localparam logic [5:0] C_RST    = 6'b000000;
  localparam logic [5:0] C_NORM   = 6'b110010;
  localparam logic [5:0] C_LUSE   = 6'b000110;
  localparam logic [5:0] C_REDIR  = 6'b111110;
  localparam logic [5:0] C_SQUASH = 6'b111010;
  localparam logic [5:0] C_FREEZE = 6'b000001;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  hazard_stall_unit_if #(.CNT_W(CW)) hif ();

  hazard_stall_unit #(
    .FLUSH_EXTRA(2),
    .MEM_TIMEOUT(8),
    .CNT_W      (CW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .hz   (hif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [5:0] ctl();
    return {hif.pc_write, hif.if_id_write, hif.if_id_flush,
            hif.id_ex_flush, hif.ex_mem_write, hif.mem_wb_bubble};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    hif.rs1_if_id = 5'd0; hif.rs2_if_id = 5'd0;
    hif.rs1_used = 1'b0;  hif.rs2_used = 1'b0;
    hif.rd_id_ex = 5'd0;  hif.mem_read_id_ex = 1'b0;
    hif.branch_taken_ex = 1'b0;
    hif.dmem_req = 1'b0;  hif.dmem_ready = 1'b0;
    hif.stall_clr = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    #2;
    total++; if (ctl() !== C_RST) begin bad++; $display("[TB] FAIL reset_ctl got=%b want=%b", ctl(), C_RST); end
    total++; if (hif.stall_cycles !== 4'd0 || hif.flush_events !== 4'd0 || hif.mem_timeout !== 1'b0) begin
      bad++; $display("[TB] FAIL reset_cnt got=%0d/%0d/%b want=0/0/0", hif.stall_cycles, hif.flush_events, hif.mem_timeout);
    end
    step();
    rst_n = 1'b1;
    #1;
    total++; if (ctl() !== C_NORM) begin bad++; $display("[TB] FAIL post_reset_ctl got=%b want=%b", ctl(), C_NORM); end
  endtask

  task automatic test_load_use();
    hif.mem_read_id_ex = 1'b1; hif.rd_id_ex = 5'd5;
    hif.rs1_if_id = 5'd5; hif.rs1_used = 1'b1;
    #1;
    total++; if (ctl() !== C_LUSE) begin bad++; $display("[TB] FAIL luse_ctl got=%b want=%b", ctl(), C_LUSE); end
    step();
    clear_inputs();
    #1;
    total++; if (hif.stall_cycles !== 4'd1) begin bad++; $display("[TB] FAIL luse_cnt got=%0d want=1", hif.stall_cycles); end
    total++; if (ctl() !== C_NORM) begin bad++; $display("[TB] FAIL luse_release got=%b want=%b", ctl(), C_NORM); end
  endtask

  task automatic test_no_stall();
    hif.mem_read_id_ex = 1'b1; hif.rd_id_ex = 5'd0;
    hif.rs1_if_id = 5'd0; hif.rs1_used = 1'b1;
    #1;
    total++; if (ctl() !== C_NORM) begin bad++; $display("[TB] FAIL rd_zero got=%b want=%b", ctl(), C_NORM); end
    step();
    hif.rd_id_ex = 5'd7; hif.rs1_if_id = 5'd3; hif.rs2_if_id = 5'd7; hif.rs2_used = 1'b0;
    #1;
    total++; if (ctl() !== C_NORM) begin bad++; $display("[TB] FAIL rs2_unused got=%b want=%b", ctl(), C_NORM); end
    step();
    hif.rs2_used = 1'b1;
    #1;
    total++; if (ctl() !== C_LUSE) begin bad++; $display("[TB] FAIL rs2_luse got=%b want=%b", ctl(), C_LUSE); end
    step();
    clear_inputs();
    #1;
    total++; if (hif.stall_cycles !== 4'd2) begin bad++; $display("[TB] FAIL no_stall_cnt got=%0d want=2", hif.stall_cycles); end
  endtask

  task automatic test_branch();
    hif.branch_taken_ex = 1'b1;
    #1;
    total++; if (ctl() !== C_REDIR) begin bad++; $display("[TB] FAIL br_redirect got=%b want=%b", ctl(), C_REDIR); end
    step();
    hif.branch_taken_ex = 1'b0;
    hif.mem_read_id_ex = 1'b1; hif.rd_id_ex = 5'd9; hif.rs1_if_id = 5'd9; hif.rs1_used = 1'b1;
    #1;
    total++; if (ctl() !== C_SQUASH) begin bad++; $display("[TB] FAIL br_squash1 got=%b want=%b", ctl(), C_SQUASH); end
    total++; if (hif.flush_events !== 4'd1) begin bad++; $display("[TB] FAIL br_flush_cnt got=%0d want=1", hif.flush_events); end
    step();
    clear_inputs();
    hif.branch_taken_ex = 1'b1;
    #1;
    total++; if (ctl() !== C_SQUASH) begin bad++; $display("[TB] FAIL br_squash2 got=%b want=%b", ctl(), C_SQUASH); end
    step();
    hif.branch_taken_ex = 1'b0;
    #1;
    total++; if (ctl() !== C_NORM) begin bad++; $display("[TB] FAIL br_back_to_run got=%b want=%b", ctl(), C_NORM); end
    total++; if (hif.flush_events !== 4'd1 || hif.stall_cycles !== 4'd2) begin
      bad++; $display("[TB] FAIL br_ignored_cnt got=%0d/%0d want=1/2", hif.flush_events, hif.stall_cycles);
    end
  endtask

  task automatic test_freeze();
    hif.dmem_req = 1'b1; hif.dmem_ready = 1'b0; hif.branch_taken_ex = 1'b1;
    hif.mem_read_id_ex = 1'b1; hif.rd_id_ex = 5'd4; hif.rs2_if_id = 5'd4; hif.rs2_used = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++; if (ctl() !== C_FREEZE) begin bad++; $display("[TB] FAIL freeze_%0d got=%b want=%b", i, ctl(), C_FREEZE); end
      step();
    end
    hif.dmem_ready = 1'b1;
    #1;
    total++; if (ctl() !== C_REDIR) begin bad++; $display("[TB] FAIL freeze_release got=%b want=%b", ctl(), C_REDIR); end
    total++; if (hif.stall_cycles !== 4'd6) begin bad++; $display("[TB] FAIL freeze_cnt got=%0d want=6", hif.stall_cycles); end
    step();
    clear_inputs();
    #1;
    total++; if (hif.flush_events !== 4'd2 || ctl() !== C_SQUASH) begin
      bad++; $display("[TB] FAIL freeze_redirect got=%0d/%b want=2/%b", hif.flush_events, ctl(), C_SQUASH);
    end
    step();
    step();
    total++; if (ctl() !== C_NORM || hif.mem_timeout !== 1'b0) begin
      bad++; $display("[TB] FAIL freeze_end got=%b/%b want=%b/0", ctl(), hif.mem_timeout, C_NORM);
    end
  endtask

  task automatic test_timeout();
    hif.dmem_req = 1'b1; hif.dmem_ready = 1'b0;
    for (int i = 0; i < 7; i++) step();
    total++; if (hif.mem_timeout !== 1'b0) begin bad++; $display("[TB] FAIL timeout_early got=%b want=0", hif.mem_timeout); end
    step();
    total++; if (hif.mem_timeout !== 1'b1) begin bad++; $display("[TB] FAIL timeout_set got=%b want=1", hif.mem_timeout); end
    hif.dmem_ready = 1'b1;
    #1;
    total++; if (ctl() !== C_NORM) begin bad++; $display("[TB] FAIL timeout_release got=%b want=%b", ctl(), C_NORM); end
    step();
    clear_inputs();
    total++; if (hif.mem_timeout !== 1'b1 || hif.stall_cycles !== 4'd14) begin
      bad++; $display("[TB] FAIL timeout_sticky got=%b/%0d want=1/14", hif.mem_timeout, hif.stall_cycles);
    end
    hif.stall_clr = 1'b1;
    step();
    hif.stall_clr = 1'b0;
    total++; if (hif.mem_timeout !== 1'b0 || hif.stall_cycles !== 4'd0 || hif.flush_events !== 4'd0) begin
      bad++; $display("[TB] FAIL stall_clr got=%b/%0d/%0d want=0/0/0", hif.mem_timeout, hif.stall_cycles, hif.flush_events);
    end
  endtask

  task automatic test_saturation();
    hif.dmem_req = 1'b1; hif.dmem_ready = 1'b0;
    for (int i = 0; i < 17; i++) step();
    total++; if (hif.stall_cycles !== 4'd15) begin bad++; $display("[TB] FAIL sat_stall got=%0d want=15", hif.stall_cycles); end
    hif.stall_clr = 1'b1;
    step();
    total++; if (hif.stall_cycles !== 4'd0 || hif.mem_timeout !== 1'b0) begin
      bad++; $display("[TB] FAIL clr_priority got=%0d/%b want=0/0", hif.stall_cycles, hif.mem_timeout);
    end
    clear_inputs();
    step();
  endtask

  task automatic test_reset_mid_flush();
    hif.branch_taken_ex = 1'b1;
    step();
    hif.branch_taken_ex = 1'b0;
    total++; if (hif.flush_events !== 4'd1) begin bad++; $display("[TB] FAIL rmf_flush_cnt got=%0d want=1", hif.flush_events); end
    rst_n = 1'b0;
    #1;
    total++; if (ctl() !== C_RST || hif.flush_events !== 4'd0) begin
      bad++; $display("[TB] FAIL rmf_reset got=%b/%0d want=%b/0", ctl(), hif.flush_events, C_RST);
    end
    step();
    rst_n = 1'b1;
    #1;
    total++; if (ctl() !== C_NORM) begin bad++; $display("[TB] FAIL rmf_release got=%b want=%b", ctl(), C_NORM); end
    step();
    total++; if (ctl() !== C_NORM) begin bad++; $display("[TB] FAIL rmf_no_residual got=%b want=%b", ctl(), C_NORM); end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_no_stall();
    test_branch();
    test_freeze();
    test_timeout();
    test_saturation();
    test_reset_mid_flush();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
